issue_scoreboard: RTL

- In-order issue controller between the decode stage and execute.
- Tracks pending register writes with a 1-bit-per-register scoreboard and holds decode on RAW/WAW hazards or when the in-flight limit is reached.
- On a taken jump, flushes wrong-path decode slots for a fixed number of cycles.
- Provides a stall performance counter and a sticky error flag for spurious writebacks.

---
 rtl/issue_scoreboard.sv | 128 ++++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue controller with register scoreboard and flush window
module issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_rs1_en_i,
    input  logic        id_rs2_en_i,
    input  logic        id_rd_en_i,
    input  logic        ex_ready_i,
    output logic        issue_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        flush_i,
    output logic [31:0] busy_vec_o,
    output logic [3:0]  inflight_o,
    output logic [31:0] stall_cnt_o,
    output logic        err_o
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);
    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_nxt;
    logic [31:0] r_busy;
    logic [3:0]  r_inflight;
    logic [31:0] r_stall_cnt;
    logic        r_err;

    logic        w_rd_w;
    logic        w_hazard;
    logic        w_issue;
    logic        w_ready;
    logic        w_set;
    logic        w_clr;
    logic        w_spurious;
    logic        w_stall;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    assign w_rd_w = id_rd_en_i & (id_rd_addr_i != 5'd0);

    // Hazards look only at registered state; a freed register becomes issuable one cycle later.
    assign w_hazard = (id_rs1_en_i & r_busy[id_rs1_addr_i])
                    | (id_rs2_en_i & r_busy[id_rs2_addr_i])
                    | (w_rd_w & r_busy[id_rd_addr_i])
                    | (w_rd_w & (r_inflight == MAX_INF));

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_issue         = 1'b0;
        w_ready         = 1'b0;
        case (r_state)
            RUN: begin
                w_issue = id_valid_i & ex_ready_i & ~w_hazard & ~flush_i;
                w_ready = w_issue | flush_i;
                if (flush_i) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FLUSH_LD;
                end
            end
            FLUSH: begin
                w_ready = 1'b1;
                if (flush_i) begin
                    w_flush_cnt_nxt = FLUSH_LD;
                end else if (r_flush_cnt == 3'd1) begin
                    w_state_nxt     = RUN;
                    w_flush_cnt_nxt = 3'd0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    assign w_set      = w_issue & w_rd_w;
    assign w_clr      = wb_valid_i & r_busy[wb_rd_addr_i];
    assign w_spurious = wb_valid_i & ~r_busy[wb_rd_addr_i];
    assign w_set_mask = {31'd0, w_set} << id_rd_addr_i;
    assign w_clr_mask = {31'd0, w_clr} << wb_rd_addr_i;
    assign w_stall    = (r_state == RUN) & id_valid_i & ~flush_i & ~w_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= 3'd0;
            r_busy      <= 32'd0;
            r_inflight  <= 4'd0;
            r_stall_cnt <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_busy      <= (r_busy | w_set_mask) & ~w_clr_mask & ~32'd1;
            r_inflight  <= r_inflight + {3'd0, w_set} - {3'd0, w_clr};
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign issue_o     = w_issue;
    assign id_ready_o  = w_ready;
    assign busy_vec_o  = r_busy;
    assign inflight_o  = r_inflight;
    assign stall_cnt_o = r_stall_cnt;
    assign err_o       = r_err;

endmodule
